vga_capture: RTL and testbench
==============================

// Module: vga_capture
// PURPOSE
//   Receiving end of the VGA pixel interface: samples hsync/vsync/blank_n/RGB as
//   driven by the VGA timing generator, recovers pixel coordinates, and emits
//   framebuffer write strobes (x, y, rgb).
//   Locks only after a full frame checks correct against the nominal timing, and
//   flags timing violations.
//   Used as a loopback checker/capture block beside the display path, in the same
//   pixel-clock domain.
// PARAMETERS
//   H_ACTIVE  640  visible pixels per line
//   H_TOTAL   800  pixel clocks per line (hsync assert to hsync assert)
//   V_ACTIVE  480  visible lines per frame
//   V_TOTAL   525  lines per frame (vsync assert to vsync assert)
// PORTS
//   clock       in   1   pixel clock
//   reset       in   1   asynchronous, active-high reset
//   hsync       in   1   horizontal sync, active low
//   vsync       in   1   vertical sync, active low
//   blank_n     in   1   1 = active pixel on r/g/b this cycle
//   vga_r       in   8   red
//   vga_g       in   8   green
//   vga_b       in   8   blue
//   pix_we      out  1   one-cycle write strobe, one per captured pixel
//   pix_x       out  10  column of the written pixel, 0..H_ACTIVE-1
//   pix_y       out  10  row of the written pixel, 0..V_ACTIVE-1
//   pix_data    out  24  {r,g,b} of the written pixel
//   frame_start out  1   one-cycle pulse on vsync assertion while LOCK
//   locked      out  1   1 while FSM is in LOCK
//   err         out  1   one-cycle pulse on any timing violation
//   err_code    out  2   valid with err: 0 line len, 1 active width,
//                        2 frame len, 3 active lines
//   frame_cnt   out  16  frames completed in LOCK; wraps 0xFFFF->0
// BEHAVIOUR
//   Reset: every output is 0; FSM = SEEK; all counters 0.
//   Input sampling
//     - All inputs are registered once (stage S1).
//     - Edges are detected on S1 vs the previous S1 value.
//     - Sync "assert" = 1->0 transition.
//   Counters
//     - hcnt: clears to 0 on hsync assert, otherwise +1 (saturates at 1023).
//     - xcnt: counts blank_n=1 cycles; clears on hsync assert.
//     - lcnt: counts hsync asserts; clears on vsync assert.
//     - ycnt: +1 on hsync assert when the ending line had xcnt != 0; clears on vsync assert.
//   Checks, evaluated at the moment each count closes
//     - code 0: at hsync assert, hcnt+1 != H_TOTAL. Skipped for the first hsync after
//       entering SYNC.
//     - code 1: at hsync assert, xcnt not in {0, H_ACTIVE}.
//     - code 2: at vsync assert, lcnt != V_TOTAL.
//     - code 3: at vsync assert, ycnt != V_ACTIVE.
//     - If several checks fail in one cycle, the lowest code wins.
//   FSM
//     - SEEK -> SYNC on vsync assert.
//     - SYNC -> LOCK on the next vsync assert, if no error occurred in between.
//     - SYNC or LOCK -> SEEK on any error.
//     - err pulses in SYNC/LOCK only; violations seen in SEEK are ignored.
//   Writes
//     - Only in LOCK, for S1 cycles with blank_n=1, xcnt < H_ACTIVE and ycnt < V_ACTIVE.
//     - pix_we/pix_x/pix_y/pix_data are registered: pixel at the input pins in cycle N
//       appears on the outputs in cycle N+2.
//     - Extra pixels beyond H_ACTIVE are dropped, and code 1 is raised at line end.
//   frame_start, frame_cnt
//     - Both are registered, aligned with the same N+2 latency.
//     - frame_cnt increments on each vsync assert passing all checks in LOCK,
//       including the SYNC->LOCK transition.
//   Simultaneous hsync and vsync assert
//     - Line checks are applied first, then frame checks.
//     - A line error blocks the frame transition.
//   Reset mid-frame
//     - Immediate return to SEEK; outputs are 0 asynchronously.
//     - Relock needs two further vsync asserts.
// TESTING
//   - Nominal 640x480 stimulus, pixel = {x[7:0], y[7:0], 8'h5A}, 3 frames.
//     -> locked rises at 2nd vsync.
//     -> frame 3 produces exactly 307200 pix_we; pix_x/pix_y/pix_data match the pattern.
//     -> err never pulses.
//   - One line of 801 clocks in a locked frame.
//     -> err with err_code=0 at that hsync; locked=0 next cycle.
//     -> relock after 2 clean vsyncs.
//   - blank_n high for 641 pixels on line 10.
//     -> pixel 641 not written; err_code=1 at line end.
//   - Frame of 524 lines.
//     -> err_code=2 at vsync; frame_cnt unchanged.
//   - Reset asserted mid-line in LOCK.
//     -> pix_we and locked drop to 0 with no clock edge.
//     -> no writes until 2 vsyncs after release.
//   - Latency: single pixel presented at cycle N.
//     -> pix_we=1 at cycle N+2 only.

Source files
------------

// File: rtl/vga_capture.sv
// VGA receive-side capture: samples the pixel bus, recovers x/y coordinates,
// checks line/frame timing, and issues framebuffer writes once a clean frame locks.
module vga_capture #(
  parameter int H_ACTIVE = 640,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank_n,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  output logic        pix_we,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [23:0] pix_data,
  output logic        frame_start,
  output logic        locked,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {SEEK, SYNC, LOCK} state_t;

  localparam logic [9:0]  H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT   = 10'(V_ACTIVE);
  localparam logic [10:0] H_TOT   = 11'(H_TOTAL);
  localparam logic [10:0] V_TOT   = 11'(V_TOTAL);
  localparam logic [10:0] V_ACT_W = 11'(V_ACTIVE);

  state_t      state, next_state;
  logic        s1_hs, s1_vs, s1_blank, prev_hs, prev_vs;
  logic [23:0] s1_rgb;
  logic [9:0]  hcnt, xcnt, lcnt, ycnt;
  logic        skip_h;

  logic        hs_assert, vs_assert, line_had_pix;
  logic [10:0] line_len, lcnt_eff, ycnt_eff;
  logic [3:0]  chk;
  logic        any_err, err_valid, frame_ok, wr_en;
  logic [1:0]  code;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
      s1_blank <= 1'b0;
      s1_rgb   <= '0;
      prev_hs  <= 1'b0;
      prev_vs  <= 1'b0;
    end else begin
      s1_hs    <= hsync;
      s1_vs    <= vsync;
      s1_blank <= blank_n;
      s1_rgb   <= {vga_r, vga_g, vga_b};
      prev_hs  <= s1_hs;
      prev_vs  <= s1_vs;
    end
  end

  assign hs_assert    = prev_hs & ~s1_hs;
  assign vs_assert    = prev_vs & ~s1_vs;
  assign line_had_pix = (xcnt != 10'd0);

  // A sync edge coinciding with hsync closes the line first, so the frame
  // totals include the line that ends on this very cycle.
  assign line_len = {1'b0, hcnt} + 11'd1;
  assign lcnt_eff = {1'b0, lcnt} + {10'd0, hs_assert};
  assign ycnt_eff = {1'b0, ycnt} + {10'd0, hs_assert & line_had_pix};

  assign chk[0] = hs_assert & ~skip_h & (line_len != H_TOT);
  assign chk[1] = hs_assert & line_had_pix & (xcnt != H_ACT);
  assign chk[2] = vs_assert & (lcnt_eff != V_TOT);
  assign chk[3] = vs_assert & (ycnt_eff != V_ACT_W);
  assign any_err = |chk;

  always_comb begin
    code = 2'd0;
    if (chk[0])      code = 2'd0;
    else if (chk[1]) code = 2'd1;
    else if (chk[2]) code = 2'd2;
    else if (chk[3]) code = 2'd3;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hcnt <= '0;
      xcnt <= '0;
      lcnt <= '0;
      ycnt <= '0;
    end else begin
      hcnt <= hs_assert ? 10'd0 : sat_inc(hcnt);
      if (hs_assert)     xcnt <= 10'd0;
      else if (s1_blank) xcnt <= sat_inc(xcnt);
      if (vs_assert)      lcnt <= 10'd0;
      else if (hs_assert) lcnt <= sat_inc(lcnt);
      if (vs_assert)                      ycnt <= 10'd0;
      else if (hs_assert && line_had_pix) ycnt <= sat_inc(ycnt);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      SEEK:    if (vs_assert) next_state = SYNC;
      SYNC: begin
        if (any_err)        next_state = SEEK;
        else if (vs_assert) next_state = LOCK;
      end
      LOCK:    if (any_err) next_state = SEEK;
      default: next_state = SEEK;
    endcase
  end

  // The line in progress when SYNC is entered started before we were watching,
  // so its length is not trusted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= SEEK;
      skip_h <= 1'b0;
    end else begin
      state <= next_state;
      if (state == SEEK && next_state == SYNC) skip_h <= 1'b1;
      else if (hs_assert)                      skip_h <= 1'b0;
    end
  end

  assign locked    = (state == LOCK);
  assign err_valid = any_err & (state != SEEK);
  assign frame_ok  = vs_assert & ~any_err & (state != SEEK);
  assign wr_en     = (state == LOCK) & s1_blank & (xcnt < H_ACT) & (ycnt < V_ACT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pix_we      <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_data    <= '0;
      frame_start <= 1'b0;
      err         <= 1'b0;
      err_code    <= '0;
      frame_cnt   <= '0;
    end else begin
      pix_we      <= wr_en;
      if (wr_en) begin
        pix_x    <= xcnt;
        pix_y    <= ycnt;
        pix_data <= s1_rgb;
      end
      frame_start <= frame_ok;
      err         <= err_valid;
      err_code    <= err_valid ? code : 2'd0;
      if (frame_ok) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_vga_capture.sv
// Scoreboard bench for vga_capture on a scaled-down raster (16x6 active in 24x10 total)
// so many frames fit in a short run.
module tb_vga_capture;

  localparam int H_ACTIVE = 16;
  localparam int H_TOTAL  = 24;
  localparam int V_ACTIVE = 6;
  localparam int V_TOTAL  = 10;

  logic        clock, reset, hsync, vsync, blank_n;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        pix_we, frame_start, locked, err;
  logic [9:0]  pix_x, pix_y;
  logic [23:0] pix_data;
  logic [1:0]  err_code;
  logic [15:0] frame_cnt;

  int checks = 0;
  int failures = 0;
  int wr_seen = 0;
  int wr_mark;
  logic [43:0] pix_q[$];
  logic [1:0]  err_q[$];

  vga_capture #(
    .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL), .V_ACTIVE(V_ACTIVE), .V_TOTAL(V_TOTAL)
  ) dut (
    .clock(clock), .reset(reset), .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .pix_we(pix_we), .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data),
    .frame_start(frame_start), .locked(locked), .err(err), .err_code(err_code),
    .frame_cnt(frame_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_cycle(input logic hs, input logic vs, input logic bl,
                             input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    hsync = hs; vsync = vs; blank_n = bl;
    vga_r = r; vga_g = g; vga_b = b;
    @(posedge clock);
    #1;
  endtask

  // One line: hsync low for two clocks, pixels from clock 4; expected writes
  // are queued as each pixel is driven.
  task automatic apply_line(input logic vs, input int row, input int n_pix, input int len,
                            input bit exp_wr, input bit lat_chk, input int stop_at);
    int  px;
    bit  act;
    for (int c = 0; c < len; c++) begin
      if (c == stop_at) return;
      px  = c - 4;
      act = (row >= 0) && (px >= 0) && (px < n_pix);
      if (act && exp_wr && px < H_ACTIVE)
        pix_q.push_back({10'(px), 10'(row), 8'(px), 8'(row), 8'h5A});
      drive_cycle((c < 2) ? 1'b0 : 1'b1, vs, act,
                  act ? 8'(px) : 8'h00, act ? 8'(row) : 8'h00, act ? 8'h5A : 8'h00);
      if (lat_chk && c >= 4 && c <= 6)
        check_output($sformatf("latency_n%0d", c - 3), 64'(pix_we), 64'(c == 5));
    end
  endtask

  // bad_kind: 1 = line one clock long, 2 = one extra active pixel, 3 = single pixel
  task automatic apply_stimulus(input bit exp_wr, input int n_lines, input int bad_line,
                                input int bad_kind, input int stop_line);
    bit wr;
    int row, npx, len;
    wr = exp_wr;
    for (int l = 0; l < n_lines; l++) begin
      row = (l >= 2 && l < 2 + V_ACTIVE) ? l - 2 : -1;
      npx = H_ACTIVE;
      len = H_TOTAL;
      if (l == bad_line) begin
        case (bad_kind)
          1: begin len = H_TOTAL + 1; err_q.push_back(2'd0); end
          2: begin npx = H_ACTIVE + 1; err_q.push_back(2'd1); end
          3: begin npx = 1; err_q.push_back(2'd1); end
          default: ;
        endcase
      end
      apply_line((l < 2) ? 1'b0 : 1'b1, row, npx, len, wr,
                 (l == bad_line) && (bad_kind == 3), (l == stop_line) ? 10 : -1);
      if (l == stop_line) return;
      if (l == bad_line && bad_kind != 0) wr = 1'b0;
    end
    if (n_lines != V_TOTAL) err_q.push_back(2'd2);
  endtask

  task automatic expect_state(input string tag, input logic exp_lock, input int exp_cnt);
    check_output({tag, "_locked"}, 64'(locked), 64'(exp_lock));
    if (exp_cnt >= 0) check_output({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(exp_cnt));
  endtask

  // Monitor: every write and every error pulse must match the next queued expectation.
  always @(negedge clock) begin
    if (pix_we) begin
      wr_seen++;
      if (pix_q.size() == 0) check_output("unexpected_write", 64'(pix_we), 64'd0);
      else check_output("pixel", 64'({pix_x, pix_y, pix_data}), 64'(pix_q.pop_front()));
    end
    if (err) begin
      if (err_q.size() == 0) check_output("unexpected_err", 64'(err_code), 64'hFF);
      else check_output("err_code", 64'(err_code), 64'(err_q.pop_front()));
      check_output("locked_with_err", 64'(locked), 64'd0);
    end
    if (frame_start) check_output("frame_start_locked", 64'(locked), 64'd1);
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1; hsync = 1'b1; vsync = 1'b1; blank_n = 1'b0;
    vga_r = '0; vga_g = '0; vga_b = '0;
    repeat (3) @(posedge clock);
    #1;
    check_output("reset_pix_we", 64'(pix_we), 64'd0);
    check_output("reset_locked", 64'(locked), 64'd0);
    check_output("reset_err", 64'({err, err_code}), 64'd0);
    check_output("reset_frame_cnt", 64'(frame_cnt), 64'd0);
    check_output("reset_frame_start", 64'(frame_start), 64'd0);
    reset = 1'b0;
    repeat (5) drive_cycle(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);

    // Nominal: lock at the second vsync, full frames written afterwards
    apply_stimulus(0, V_TOTAL, -1, 0, -1); expect_state("frame_a", 1'b0, 0);
    apply_stimulus(1, V_TOTAL, -1, 0, -1); expect_state("frame_b", 1'b1, 1);
    wr_mark = wr_seen;
    apply_stimulus(1, V_TOTAL, -1, 0, -1); expect_state("frame_c", 1'b1, 2);
    check_output("frame_c_writes", 64'(wr_seen - wr_mark), 64'(H_ACTIVE * V_ACTIVE));

    // Over-long line, then relock
    apply_stimulus(1, V_TOTAL, 4, 1, -1); expect_state("long_line", 1'b0, 3);
    apply_stimulus(0, V_TOTAL, -1, 0, -1); expect_state("relock1_sync", 1'b0, 3);
    apply_stimulus(1, V_TOTAL, -1, 0, -1); expect_state("relock1_lock", 1'b1, 4);

    // One pixel too many on a line
    apply_stimulus(1, V_TOTAL, 4, 2, -1); expect_state("wide_line", 1'b0, 5);
    apply_stimulus(0, V_TOTAL, -1, 0, -1); expect_state("relock2_sync", 1'b0, 5);
    apply_stimulus(1, V_TOTAL, -1, 0, -1); expect_state("relock2_lock", 1'b1, 6);

    // Short frame: error at its closing vsync, count unchanged
    apply_stimulus(1, V_TOTAL - 1, -1, 0, -1); expect_state("short_frame", 1'b1, 7);
    apply_stimulus(0, V_TOTAL, -1, 0, -1); expect_state("after_short", 1'b0, 7);
    apply_stimulus(0, V_TOTAL, -1, 0, -1); expect_state("relock3_sync", 1'b0, 7);
    apply_stimulus(1, V_TOTAL, -1, 0, -1); expect_state("relock3_lock", 1'b1, 8);

    // Asynchronous reset mid-line while writing
    apply_stimulus(1, V_TOTAL, -1, 0, 3);
    check_output("pre_reset_we", 64'(pix_we), 64'd1);
    check_output("pre_reset_locked", 64'(locked), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    check_output("async_reset_we", 64'(pix_we), 64'd0);
    check_output("async_reset_locked", 64'(locked), 64'd0);
    check_output("async_reset_frame_cnt", 64'(frame_cnt), 64'd0);
    pix_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (5) drive_cycle(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    apply_stimulus(0, V_TOTAL, -1, 0, -1); expect_state("post_reset_sync", 1'b0, 0);
    apply_stimulus(1, V_TOTAL, -1, 0, -1); expect_state("post_reset_lock", 1'b1, 1);

    // Single pixel: two-cycle latency, then line-width error
    apply_stimulus(1, V_TOTAL, 2, 3, -1); expect_state("single_pixel", 1'b0, 2);

    drive_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    drive_cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    repeat (6) drive_cycle(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    check_output("pix_queue_drained", 64'(pix_q.size()), 64'd0);
    check_output("err_queue_drained", 64'(err_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
